// File: rtl/lpm_divide_pkg.sv
// Shared types and helpers for the sequential restoring divider (lpm_divide_seq).
package lpm_divide_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   localparam int MAX_WIDTH = 64;

   function automatic int cntWidth(input int widthN);
      return (widthN > 1) ? $clog2(widthN) : 1;
   endfunction

   // Bit pattern of the most-negative two's complement value of a given width.
   function automatic logic [MAX_WIDTH-1:0] mostNeg(input int width);
      return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
   endfunction

endpackage

// File: rtl/lpm_divide_step.sv
// One combinational restoring-division iteration: shift in a numerator bit, trial-subtract.
module lpm_divide_step #(
   parameter int WIDTHD = 4
) (
   input  logic [WIDTHD:0]   i_rem,
   input  logic              i_numBit,
   input  logic [WIDTHD-1:0] i_denom,
   output logic [WIDTHD:0]   o_rem,
   output logic              o_qBit
);

   logic [WIDTHD+1:0] w_shift;
   logic [WIDTHD+1:0] w_trial;

   // The extra top bit of the trial difference acts as its sign.
   always_comb begin
      w_shift = {i_rem, i_numBit};
      w_trial = w_shift - {2'b00, i_denom};
      o_qBit  = ~w_trial[WIDTHD+1];
      o_rem   = o_qBit ? w_trial[WIDTHD:0] : w_shift[WIDTHD:0];
   end

endmodule

// File: rtl/lpm_divide_seq.sv
// Iterative signed/unsigned restoring divider, one quotient bit per clock.
// Optional macro LPM_DIVIDE_SEQ_REMPOS_EN forces a non-negative remainder.
module lpm_divide_seq
   import lpm_divide_pkg::*;
#(
   parameter int WIDTHN = 8,
   parameter int WIDTHD = 4
) (
   input  logic              i_clock,
   input  logic              i_aclr,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [WIDTHN-1:0] i_numer,
   input  logic [WIDTHD-1:0] i_denom,
   input  logic              i_signed,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [WIDTHN-1:0] o_quotient,
   output logic [WIDTHD-1:0] o_remain,
   output logic              o_dbz,
   output logic              o_ovf
);

   localparam int CW = cntWidth(WIDTHN);
   localparam logic [WIDTHN-1:0] NUMER_MIN     = WIDTHN'(mostNeg(WIDTHN));
   localparam logic [WIDTHD-1:0] DENOM_NEG_ONE = '1;

   state_t            r_state;
   logic [CW-1:0]     r_count;
   logic [WIDTHD:0]   r_rem;
   logic [WIDTHN-1:0] r_num;
   logic [WIDTHD-1:0] r_denAbs;
   logic [WIDTHD-1:0] r_numLow;
   logic              r_signN;
   logic              r_signD;
   logic              r_ovfCase;
   logic              r_valid;
   logic [WIDTHN-1:0] r_quotient;
   logic [WIDTHD-1:0] r_remain;
   logic              r_dbz;
   logic              r_ovf;

   logic              w_accept;
   logic              w_signN;
   logic              w_signD;
   logic [WIDTHN-1:0] w_numAbs;
   logic [WIDTHD-1:0] w_denAbs;
   logic [WIDTHD:0]   w_stepRem;
   logic              w_stepQ;
   logic              w_remNeg;
   logic [WIDTHN-1:0] w_qFix;
   logic [WIDTHD-1:0] w_rFix;

   assign o_ready    = (r_state == IDLE) || ((r_state == DONE) && i_ready);
   assign w_accept   = i_valid && o_ready;
   assign o_valid    = r_valid;
   assign o_quotient = r_quotient;
   assign o_remain   = r_remain;
   assign o_dbz      = r_dbz;
   assign o_ovf      = r_ovf;

   // Magnitudes use the raw bit pattern, so the most-negative value maps to 2^(W-1).
   always_comb begin
      w_signN  = i_signed && i_numer[WIDTHN-1];
      w_signD  = i_signed && i_denom[WIDTHD-1];
      w_numAbs = w_signN ? -i_numer : i_numer;
      w_denAbs = w_signD ? -i_denom : i_denom;
   end

   lpm_divide_step #(
      .WIDTHD (WIDTHD)
   ) u_step (
      .i_rem    (r_rem),
      .i_numBit (r_num[WIDTHN-1]),
      .i_denom  (r_denAbs),
      .o_rem    (w_stepRem),
      .o_qBit   (w_stepQ)
   );

   // Truncating sign correction: remainder follows the numerator's sign.
   always_comb begin
      w_remNeg = r_signN && (r_rem[WIDTHD-1:0] != '0);
      w_qFix   = (r_signN ^ r_signD) ? -r_num : r_num;
      w_rFix   = w_remNeg ? -r_rem[WIDTHD-1:0] : r_rem[WIDTHD-1:0];
`ifdef LPM_DIVIDE_SEQ_REMPOS_EN
      if (w_remNeg) begin
         w_rFix = w_rFix + r_denAbs;
         w_qFix = r_signD ? (w_qFix + WIDTHN'(1)) : (w_qFix - WIDTHN'(1));
      end
`endif
   end

   always_ff @(posedge i_clock or posedge i_aclr) begin
      if (i_aclr) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_rem      <= '0;
         r_num      <= '0;
         r_denAbs   <= '0;
         r_numLow   <= '0;
         r_signN    <= 1'b0;
         r_signD    <= 1'b0;
         r_ovfCase  <= 1'b0;
         r_valid    <= 1'b0;
         r_quotient <= '0;
         r_remain   <= '0;
         r_dbz      <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         case (r_state)
            CALC: begin
               r_rem <= w_stepRem;
               r_num <= {r_num[WIDTHN-2:0], w_stepQ};
               if (r_count == CW'(WIDTHN - 1)) begin
                  r_state <= FIX;
               end else begin
                  r_count <= r_count + CW'(1);
               end
            end
            FIX: begin
               r_valid <= 1'b1;
               r_state <= DONE;
               if (r_denAbs == '0) begin
                  r_quotient <= '1;
                  r_remain   <= r_numLow;
                  r_dbz      <= 1'b1;
                  r_ovf      <= 1'b0;
               end else begin
                  r_quotient <= w_qFix;
                  r_remain   <= w_rFix;
                  r_dbz      <= 1'b0;
                  r_ovf      <= r_ovfCase;
               end
            end
            DONE: begin
               if (i_ready) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: ;
         endcase

         // A new request from IDLE or from a consumed DONE overrides the above.
         if (w_accept) begin
            r_state   <= CALC;
            r_count   <= '0;
            r_rem     <= '0;
            r_num     <= w_numAbs;
            r_denAbs  <= w_denAbs;
            r_numLow  <= i_numer[WIDTHD-1:0];
            r_signN   <= w_signN;
            r_signD   <= w_signD;
            r_ovfCase <= i_signed && (i_numer == NUMER_MIN) && (i_denom == DENOM_NEG_ONE);
         end
      end
   end

endmodule

// File: doc/lpm_divide_seq.md
Name: lpm_divide_seq

Overview:
- Iterative, multi-cycle integer divider; the area-lean successor to the fully combinational/pipelined divide macro.
- Produces one quotient bit per clock using restoring division.
- Operand signedness is selectable per transaction; adds divide-by-zero and signed-overflow flags.
- Valid/ready handshake on both sides; sits inside datapath blocks that tolerate variable latency (address scalers, rate converters).

Parameters:
- WIDTHN, 8: numerator and quotient width, >= 2.
- WIDTHD, 4: denominator and remainder width, 2..WIDTHN.

Ports:
- i_clock  in  1  clock, rising edge.
- i_aclr  in  1  reset, asynchronous, active-high.
- i_valid  in  1  request valid.
- o_ready  out  1  divider can accept a request.
- i_numer  in  WIDTHN  numerator.
- i_denom  in  WIDTHD  denominator.
- i_signed  in  1  1 = both operands two's complement; 0 = unsigned.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_quotient  out  WIDTHN  quotient.
- o_remain  out  WIDTHD  remainder.
- o_dbz  out  1  divide-by-zero flag, valid with o_valid.
- o_ovf  out  1  signed overflow flag, valid with o_valid.

Behaviour:
- Reset: i_clock and i_aclr as decided above (asynchronous, active-high). On reset: state=IDLE, o_valid=0, o_quotient=0, o_remain=0, o_dbz=0, o_ovf=0, iteration counter=0. o_ready=1 once out of reset.
- Reset mid-operation: the transaction is discarded immediately; no result is produced.
- States: IDLE, CALC, FIX, DONE.
- o_ready = (state==IDLE) || (state==DONE && i_ready).
- Accept occurs when i_valid && o_ready.
  - Latch i_signed, sign_n, sign_d.
  - Latch |numer| (WIDTHN bits) and |denom| (WIDTHD bits); abs uses the unsigned bit pattern, so the most-negative value stays 2^(W-1).
  - Clear the partial remainder (WIDTHD+1 bits) and counter.
  - Next state CALC.
- CALC, once per cycle:
  - Shift {rem, num} left 1.
  - Trial-subtract |denom|; if non-negative, keep the difference and set the quotient LSB to 1, else restore and set it to 0.
  - After WIDTHN iterations (counter == WIDTHN-1), go to FIX.
- FIX (1 cycle), sign correction:
  - Negate q if sign_n^sign_d.
  - Negate r if sign_n and r!=0 (truncating division: remainder takes the numerator's sign).
  - Register the outputs; go to DONE.
- Latency: accept on edge k gives o_valid=1 after edge k+WIDTHN+1. The latency is fixed for all operands.
- DONE:
  - Outputs and flags are held stable while o_valid && !i_ready.
  - On i_ready, either go to IDLE (o_valid=0), or, if i_valid, accept the new request the same cycle (back-to-back) and go to CALC.
- Divide by zero (|denom|==0):
  - Iterations run normally (uniform latency).
  - FIX forces o_quotient=all ones, o_remain=i_numer[WIDTHD-1:0] (raw pattern, no sign fix), o_dbz=1, o_ovf=0.
- Signed overflow:
  - Applies when i_signed, numer = -2^(WIDTHN-1), denom = -1.
  - o_quotient = 0x80.. (natural wrap), o_remain=0, o_ovf=1.
- Unsigned mode: sign_n=sign_d=0; o_ovf is always 0.
- Inputs are sampled only at accept; changes during CALC are ignored.

Optional Feature:
- Macro: LPM_DIVIDE_SEQ_REMPOS_EN.
- Defined: FIX additionally enforces a non-negative remainder.
  - If the corrected remainder is negative: r += |denom|; q -= 1 if sign_d==0, else q += 1.
  - Applied in the same FIX cycle; latency unchanged.
  - Not applied on dbz.
- Undefined: truncating result only; the remainder carries the numerator's sign.

Decomposition:
- Package lpm_divide_pkg holds:
  - state enum {IDLE, CALC, FIX, DONE};
  - function for counter width = $clog2(WIDTHN);
  - localparam helpers for the most-negative constants.
- Sub-module lpm_divide_step: combinational single restoring iteration.
  - Inputs: partial remainder, next numerator bit, |denom|.
  - Outputs: new remainder, quotient bit.
  - Instantiated once in the CALC datapath.

Test Plan (WIDTHN=8, WIDTHD=4):
- Unsigned 200/7 accepted at edge k -> o_valid after edge k+9; q=8'd28, r=4'd4, dbz=0, ovf=0.
- Signed 8'hF9 (-7) / 4'h2 -> macro off: q=8'hFD (-3), r=4'hF (-1). Macro on: q=8'hFC (-4), r=4'h1. Also check -7/-2: off q=8'h03, r=4'hF; on q=8'h04, r=4'h1.
- Unsigned 100/0 -> q=8'hFF, r=4'h4, o_dbz=1, same latency as the nonzero case.
- Signed 8'h80 / 4'hF -> q=8'h80, r=4'h0, o_ovf=1.
- i_ready held low 5 cycles after o_valid -> outputs and flags constant, o_ready=0. Raise i_ready with i_valid=1 (13/3 unsigned) -> accepted same cycle; next result q=4, r=1 after WIDTHN+1 cycles.
- Assert i_aclr during the 4th CALC cycle -> all outputs 0 and o_ready=1 the cycle after release; the aborted transaction never produces o_valid.
